// File: rtl/wb_line_prefetcher.sv
// wb_line_prefetcher
//   Single-line read buffer between the SoC Wishbone master and a slow
//   Wishbone slave. A cacheable read miss fetches one aligned line of
//   LINE_WORDS words; later reads hitting that line are acked in one cycle
//   without touching the slave. Writes and uncacheable reads pass through;
//   a write hitting the buffered line also updates it (write-through).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_*             upstream Wishbone slave side (from the master)
//   m_*             downstream Wishbone master side (to the slow slave)
//   flush_i         invalidate the buffered line
//   miss_cnt_o      saturating count of cacheable read misses
module wb_line_prefetcher #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [11:0] REGION     = 12'h380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic        s_ack_o,
    output logic [31:0] s_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    input  logic        flush_i,
    output logic [15:0] miss_cnt_o
);

    localparam int unsigned IW = $clog2(LINE_WORDS);
    localparam int unsigned TW = 30 - IW;
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    state_t         state_q, state_d;
    logic [31:0]    line_q [LINE_WORDS];
    logic [31:0]    line_d [LINE_WORDS];
    logic [TW-1:0]  tag_q, tag_d;
    logic           valid_q, valid_d;
    logic [IW-1:0]  word_q, word_d;
    logic [IW-1:0]  beat_q, beat_d;
    logic           flushed_q, flushed_d;
    logic           abort_q, abort_d;
    logic           we_q, we_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic           s_ack_q, s_ack_d;
    logic [31:0]    s_dat_q, s_dat_d;
    logic [15:0]    miss_q, miss_d;

    logic           req;
    logic           cacheable;
    logic           hit;
    logic [TW-1:0]  req_tag;
    logic [IW-1:0]  req_word;
    logic [IW-1:0]  pass_word;

    assign req       = s_cyc_i & s_stb_i & ~s_ack_q;
    assign req_tag   = s_adr_i[31:2+IW];
    assign req_word  = s_adr_i[2 +: IW];
    assign cacheable = (s_adr_i[31:20] == REGION);
    // A flush in the same cycle as a request beats the request's lookup.
    assign hit       = valid_q & ~flush_i & (tag_q == req_tag);
    assign pass_word = adr_q[2 +: IW];

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        word_d    = word_q;
        beat_d    = beat_q;
        flushed_d = flushed_q;
        abort_d   = abort_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        s_ack_d   = 1'b0;
        s_dat_d   = s_dat_q;
        miss_d    = miss_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!s_we_i && cacheable) begin
                        if (hit) begin
                            s_ack_d = 1'b1;
                            s_dat_d = line_q[req_word];
                        end else begin
                            tag_d     = req_tag;
                            word_d    = req_word;
                            valid_d   = 1'b0;
                            beat_d    = '0;
                            flushed_d = 1'b0;
                            abort_d   = 1'b0;
                            if (miss_q != 16'hFFFF) begin
                                miss_d = miss_q + 16'd1;
                            end
                            state_d = FILL;
                        end
                    end else begin
                        we_d    = s_we_i;
                        sel_d   = s_sel_i;
                        adr_d   = s_adr_i;
                        dat_d   = s_dat_i;
                        abort_d = 1'b0;
                        state_d = PASS;
                    end
                end
            end

            FILL: begin
                if (!s_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (m_ack_i) begin
                    line_d[beat_q] = m_dat_i;
                    beat_d         = beat_q + IW'(1);
                    if (beat_q == LAST) begin
                        state_d = IDLE;
                        valid_d = ~flushed_q & ~flush_i;
                        if (s_cyc_i && !abort_q) begin
                            s_ack_d = 1'b1;
                            // The last word is only in m_dat_i this cycle.
                            s_dat_d = (word_q == LAST) ? m_dat_i : line_q[word_q];
                        end
                    end
                end
            end

            PASS: begin
                if (!s_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (m_ack_i) begin
                    state_d = IDLE;
                    if (s_cyc_i && !abort_q) begin
                        s_ack_d = 1'b1;
                        s_dat_d = we_q ? '0 : m_dat_i;
                    end
                    if (we_q && valid_q && (adr_q[31:2+IW] == tag_q)) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (sel_q[i]) begin
                                line_d[pass_word][8*i +: 8] = dat_q[8*i +: 8];
                            end
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            line_q    <= '{default: '0};
            tag_q     <= '0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            beat_q    <= '0;
            flushed_q <= 1'b0;
            abort_q   <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            s_ack_q   <= 1'b0;
            s_dat_q   <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            beat_q    <= beat_d;
            flushed_q <= flushed_d;
            abort_q   <= abort_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            s_ack_q   <= s_ack_d;
            s_dat_q   <= s_dat_d;
            miss_q    <= miss_d;
        end
    end

    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = '0;
        m_adr_o = '0;
        m_dat_o = '0;
        case (state_q)
            FILL: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_sel_o = 4'hF;
                m_adr_o = {tag_q, beat_q, 2'b00};
            end
            PASS: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = we_q;
                m_sel_o = sel_q;
                m_adr_o = adr_q;
                m_dat_o = we_q ? dat_q : '0;
            end
            default: ;
        endcase
    end

    assign s_ack_o    = s_ack_q;
    assign s_dat_o    = s_dat_q;
    assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_wb_line_prefetcher.sv
// tb_wb_line_prefetcher
//   Directed bench for wb_line_prefetcher (LINE_WORDS=4). The downstream
//   slave returns mem[a] = a + 1 after a fixed 11-cycle latency and logs
//   every transaction it acks.
module tb_wb_line_prefetcher;

    logic        clk;
    logic        rst;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [3:0]  s_sel_i;
    logic [31:0] s_adr_i, s_dat_i;
    logic        s_ack_o;
    logic [31:0] s_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;
    logic        flush_i;
    logic [15:0] miss_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ds_log [$];
    logic        ds_we;
    logic [3:0]  ds_sel;
    int          lat;

    wb_line_prefetcher #(.LINE_WORDS(4), .REGION(12'h380)) dut (
        .clk(clk), .rst(rst),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
        .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .flush_i(flush_i), .miss_cnt_o(miss_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slow downstream slave.
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = '0;
        ds_we   = 1'b0;
        ds_sel  = '0;
        lat     = 0;
    end

    always @(posedge clk) begin
        if (m_cyc_o && m_stb_o && !m_ack_i) begin
            if (lat == 10) begin
                m_ack_i <= 1'b1;
                m_dat_i <= m_we_o ? 32'h0 : m_adr_o + 32'd1;
                ds_log.push_back(m_adr_o);
                ds_we  <= m_we_o;
                ds_sel <= m_sel_o;
                lat    <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else begin
            m_ack_i <= 1'b0;
            lat     <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One upstream transfer; returns read data, cycles to ack and whether
    // m_cyc_o was seen high while waiting.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input logic flush,
                           output logic [31:0] rdat, output int cycles, output logic cyc_hi);
        logic got;
        @(negedge clk);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i  = we;
        s_sel_i = sel;
        s_adr_i = adr;
        s_dat_i = wdat;
        flush_i = flush;
        got     = 1'b0;
        cycles  = 0;
        cyc_hi  = 1'b0;
        rdat    = '0;
        while (!got && cycles < 200) begin
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            cycles++;
            if (m_cyc_o) cyc_hi = 1'b1;
            if (s_ack_o) begin
                got  = 1'b1;
                rdat = s_dat_o;
            end
        end
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check("ack_pulse", 32'(s_ack_o), 32'd0);
    endtask

    logic [31:0] rd;
    int          cyc;
    logic        chi;
    int          waited;
    logic        ack_during;

    initial begin
        rst     = 1'b1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        s_sel_i = '0;
        s_adr_i = '0;
        s_dat_i = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ack", 32'(s_ack_o), 32'd0);
        check("rst_s_dat", s_dat_o, 32'h0);
        check("rst_m_cyc", 32'(m_cyc_o), 32'd0);
        check("rst_m_adr", m_adr_o, 32'h0);
        check("rst_miss", 32'(miss_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss: full line fill, requested word returned.
        ds_log.delete();
        wb_xfer(32'h3800_0014, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("cold_data", rd, 32'h3800_0015);
        check("cold_beats", 32'(ds_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ds_log.size()) check("cold_adr", ds_log[i], 32'h3800_0010 + 32'(4 * i));
        end
        check("cold_miss", 32'(miss_cnt_o), 32'd1);

        // Hit on the last word: 1-cycle ack, no downstream activity.
        ds_log.delete();
        wb_xfer(32'h3800_001C, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("hit_data", rd, 32'h3800_001D);
        check("hit_cycles", 32'(cyc), 32'd1);
        check("hit_no_cyc", 32'(chi), 32'd0);

        // Partial write-through, then read the updated word from the line.
        ds_log.delete();
        wb_xfer(32'h3800_0018, 1'b1, 4'b0011, 32'hFFFF_FFFF, 1'b0, rd, cyc, chi);
        check("wr_beats", 32'(ds_log.size()), 32'd1);
        check("wr_we", 32'(ds_we), 32'd1);
        check("wr_sel", 32'(ds_sel), 32'h3);
        check("wr_sdat", rd, 32'h0);
        ds_log.delete();
        wb_xfer(32'h3800_0018, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("wr_hit_data", rd, 32'h3800_FFFF);
        check("wr_hit_cycles", 32'(cyc), 32'd1);
        check("wr_hit_beats", 32'(ds_log.size()), 32'd0);

        // Uncacheable reads pass through and leave the line alone.
        for (int k = 0; k < 2; k++) begin
            ds_log.delete();
            wb_xfer(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
            check("unc_data", rd, 32'h0000_1001);
            check("unc_beats", 32'(ds_log.size()), 32'd1);
        end
        check("unc_miss", 32'(miss_cnt_o), 32'd1);
        wb_xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("unc_line_hit", 32'(cyc), 32'd1);
        check("unc_line_data", rd, 32'h3800_0011);

        // Flush pulse, then the same line refills.
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        ds_log.delete();
        wb_xfer(32'h3800_0010, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("flush_data", rd, 32'h3800_0011);
        check("flush_beats", 32'(ds_log.size()), 32'd4);
        check("flush_miss", 32'(miss_cnt_o), 32'd2);

        // Flush coinciding with a request to the (valid) line: a miss.
        ds_log.delete();
        wb_xfer(32'h3800_0014, 1'b0, 4'hF, 32'h0, 1'b1, rd, cyc, chi);
        check("fl_req_data", rd, 32'h3800_0015);
        check("fl_req_beats", 32'(ds_log.size()), 32'd4);
        check("fl_req_miss", 32'(miss_cnt_o), 32'd3);

        // Reset after the second beat of a fill.
        ds_log.delete();
        @(negedge clk);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i  = 1'b0;
        s_sel_i = 4'hF;
        s_adr_i = 32'h3800_0020;
        waited     = 0;
        ack_during = 1'b0;
        while (ds_log.size() < 2 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
            if (s_ack_o) ack_during = 1'b1;
        end
        check("rst_fill_beats", 32'(ds_log.size()), 32'd2);
        @(posedge clk);
        #1;
        if (s_ack_o) ack_during = 1'b1;
        check("rst_fill_noack", 32'(ack_during), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_fill_cyc", 32'(m_cyc_o), 32'd0);
        check("rst_fill_ack", 32'(s_ack_o), 32'd0);
        check("rst_fill_miss", 32'(miss_cnt_o), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;

        ds_log.delete();
        wb_xfer(32'h3800_0014, 1'b0, 4'hF, 32'h0, 1'b0, rd, cyc, chi);
        check("post_rst_data", rd, 32'h3800_0015);
        check("post_rst_beats", 32'(ds_log.size()), 32'd4);
        check("post_rst_miss", 32'(miss_cnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
